alu_pipe_mc: RTL and testbench

//  Parametrised successor to the 16-bit execute-stage ALU. WIDTH-bit operands, 6-bit opcode,

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_mul_iter.sv | 58 +++++
 rtl/alu_pipe_mc.sv | 202 ++++++++++++++++++++
 tb/tb_alu_pipe_mc.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings, flag bit positions and FSM states for the execute-stage ALU.
package alu_pkg;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_ADC  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_SBB  = 6'h03;
  localparam logic [5:0] OP_AND  = 6'h04;
  localparam logic [5:0] OP_OR   = 6'h05;
  localparam logic [5:0] OP_XOR  = 6'h06;
  localparam logic [5:0] OP_NOT  = 6'h07;
  localparam logic [5:0] OP_SHL  = 6'h08;
  localparam logic [5:0] OP_SHR  = 6'h09;
  localparam logic [5:0] OP_SRA  = 6'h0A;
  localparam logic [5:0] OP_ROL  = 6'h0B;
  localparam logic [5:0] OP_ROR  = 6'h0C;
  localparam logic [5:0] OP_INC  = 6'h0D;
  localparam logic [5:0] OP_DEC  = 6'h0E;
  localparam logic [5:0] OP_CMP  = 6'h0F;
  localparam logic [5:0] OP_MOVB = 6'h10;
  localparam logic [5:0] OP_IN   = 6'h11;
  localparam logic [5:0] OP_OUT  = 6'h12;
  localparam logic [5:0] OP_MUL  = 6'h18;

  // Bit positions inside flag_ex = {V,N,Z,C}
  localparam int unsigned F_C = 0;
  localparam int unsigned F_Z = 1;
  localparam int unsigned F_N = 2;
  localparam int unsigned F_V = 3;

  typedef enum logic [0:0] {
    StIdle    = 1'b0,
    StMulBusy = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles.
// done is asserted during the final iteration with prod carrying the finished product,
// so the consumer can register the result on that same edge.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic               busy_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;

  // Accumulate the current partial product
  always_comb begin
    acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  assign done = busy_q & (cnt_q == CW'(WIDTH - 1));
  assign prod = acc_d;

  // Load operands on start, then shift multiplicand left / multiplier right each cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (start) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      acc_q    <= '0;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (done) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_pipe_mc.sv
// Execute-stage ALU with valid/ready handshakes, a registered result stage and a carry
// register for ADC/SBB. Define ALU_MUL_EN to build the iterative multiplier (MUL op);
// without it MUL decodes as an illegal op and ans_hi is tied to zero.
module alu_pipe_mc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       op_dec,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ans_ex,
  output logic [WIDTH-1:0] ans_hi,
  output logic [3:0]       flag_ex,
  output logic             err,
  output logic [WIDTH-1:0] data_out
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic             out_valid_q;
  logic [WIDTH-1:0] ans_q;
  logic [3:0]       flag_q;
  logic             err_q;
  logic [WIDTH-1:0] dout_q;
  logic             carry_q;

  logic             accept;
  logic             is_mul;

  // Single-cycle datapath results
  logic [WIDTH-1:0]   add_b, sub_b;
  logic               add_ci, sub_ci;
  logic [WIDTH:0]     sum, diff;
  logic               v_add, v_sub;
  logic [SHW-1:0]     sh;
  logic [WIDTH:0]     shl_ext, shr_ext, sra_ext;
  logic [2*WIDTH-1:0] rol_ext, ror_ext;
  logic [WIDTH-1:0]   rol_res, ror_res;
  logic [WIDTH-1:0]   res, nz_src;
  logic               res_c, res_v, res_bad, carry_upd;
  logic [3:0]         res_flags;

  // Decode and compute the single-cycle result and flags
  always_comb begin
    add_b  = (op_dec == OP_INC) ? {{(WIDTH-1){1'b0}}, 1'b1} : B;
    add_ci = (op_dec == OP_ADC) & carry_q;
    sum    = {1'b0, A} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_ci};
    v_add  = (A[WIDTH-1] == add_b[WIDTH-1]) & (sum[WIDTH-1] != A[WIDTH-1]);

    sub_b  = (op_dec == OP_DEC) ? {{(WIDTH-1){1'b0}}, 1'b1} : B;
    sub_ci = (op_dec == OP_SBB) & carry_q;
    // Bit WIDTH of the extended difference is the borrow (A < B + cin)
    diff   = {1'b0, A} - {1'b0, sub_b} - {{WIDTH{1'b0}}, sub_ci};
    v_sub  = (A[WIDTH-1] != sub_b[WIDTH-1]) & (diff[WIDTH-1] != A[WIDTH-1]);

    // Extended shifts keep the last bit shifted out in the spare position
    sh      = B[SHW-1:0];
    shl_ext = {1'b0, A} << sh;
    shr_ext = {A, 1'b0} >> sh;
    sra_ext = $signed({A, 1'b0}) >>> sh;
    rol_ext = {A, A} << sh;
    ror_ext = {A, A} >> sh;
    rol_res = rol_ext[2*WIDTH-1:WIDTH];
    ror_res = ror_ext[WIDTH-1:0];

    res       = '0;
    res_c     = 1'b0;
    res_v     = 1'b0;
    res_bad   = 1'b0;
    carry_upd = 1'b0;
    case (op_dec)
      OP_ADD, OP_ADC, OP_INC: begin
        res = sum[WIDTH-1:0]; res_c = sum[WIDTH]; res_v = v_add; carry_upd = 1'b1;
      end
      OP_SUB, OP_SBB, OP_DEC: begin
        res = diff[WIDTH-1:0]; res_c = diff[WIDTH]; res_v = v_sub; carry_upd = 1'b1;
      end
      OP_CMP: begin
        res = A; res_c = diff[WIDTH]; res_v = v_sub; carry_upd = 1'b1;
      end
      OP_AND:  res = A & B;
      OP_OR:   res = A | B;
      OP_XOR:  res = A ^ B;
      OP_NOT:  res = ~A;
      OP_SHL: begin
        res = shl_ext[WIDTH-1:0]; res_c = shl_ext[WIDTH]; carry_upd = 1'b1;
      end
      OP_SHR: begin
        res = shr_ext[WIDTH:1]; res_c = shr_ext[0]; carry_upd = 1'b1;
      end
      OP_SRA: begin
        res = sra_ext[WIDTH:1]; res_c = sra_ext[0]; carry_upd = 1'b1;
      end
      OP_ROL: begin
        res = rol_res; res_c = (sh != '0) & rol_res[0]; carry_upd = 1'b1;
      end
      OP_ROR: begin
        res = ror_res; res_c = (sh != '0) & ror_res[WIDTH-1]; carry_upd = 1'b1;
      end
      OP_MOVB: res = B;
      OP_IN:   res = data_in;
      OP_OUT:  res = A;
      default: res_bad = 1'b1;
    endcase

    // CMP reports the flags of the subtraction while passing A through
    nz_src    = (op_dec == OP_CMP) ? diff[WIDTH-1:0] : res;
    res_flags = res_bad ? 4'b0000 : {res_v, nz_src[WIDTH-1], nz_src == '0, res_c};
  end

`ifdef ALU_MUL_EN
  alu_state_e         state_q;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   hi_q;

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk   (clk),
    .reset (reset),
    .start (accept & is_mul),
    .a     (A),
    .b     (B),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  assign is_mul   = (op_dec == OP_MUL);
  assign in_ready = (state_q == StIdle) & (!out_valid_q | out_ready);
  assign ans_hi   = hi_q;
`else
  assign is_mul   = 1'b0;
  assign in_ready = !out_valid_q | out_ready;
  assign ans_hi   = '0;
`endif

  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign ans_ex    = ans_q;
  assign flag_ex   = flag_q;
  assign err       = err_q;
  assign data_out  = dout_q;

  // Result stage, carry register and MUL sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      ans_q       <= '0;
      flag_q      <= '0;
      err_q       <= 1'b0;
      dout_q      <= '0;
      carry_q     <= 1'b0;
`ifdef ALU_MUL_EN
      hi_q        <= '0;
      state_q     <= StIdle;
`endif
    end else begin
      if (accept && !is_mul) begin
        out_valid_q <= 1'b1;
        ans_q       <= res;
        flag_q      <= res_flags;
        err_q       <= res_bad;
        if (carry_upd) begin
          carry_q <= res_c;
        end
        if (op_dec == OP_OUT) begin
          dout_q <= A;
        end
`ifdef ALU_MUL_EN
        hi_q <= '0;
`endif
      end
`ifdef ALU_MUL_EN
      else if (accept) begin
        // Accept implies the result stage is empty or draining this cycle
        state_q     <= StMulBusy;
        out_valid_q <= 1'b0;
      end else if ((state_q == StMulBusy) && mul_done) begin
        state_q     <= StIdle;
        out_valid_q <= 1'b1;
        ans_q       <= mul_prod[WIDTH-1:0];
        hi_q        <= mul_prod[2*WIDTH-1:WIDTH];
        flag_q      <= {1'b0, mul_prod[WIDTH-1], mul_prod == '0, 1'b0};
        err_q       <= 1'b0;
      end
`endif
      else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe_mc.sv
// Scoreboard bench for alu_pipe_mc (WIDTH=16): stimulus pushes expected results, a monitor
// pops and compares on every output transfer. Directed checks cover reset, stall, latency.
module tb_alu_pipe_mc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  op_dec = '0;
  logic [15:0] A = '0, B = '0, data_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] ans_ex, ans_hi, data_out;
  logic [3:0]  flag_ex;
  logic        err;

  int total = 0;
  int bad = 0;

  typedef struct {
    string       nm;
    logic [15:0] ans;
    logic [15:0] hi;
    logic [3:0]  fl;
    logic        er;
    logic [15:0] dout;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] exp_dout = 16'h0000;

`ifdef ALU_MUL_EN
  localparam int MUL_LAT = 17;
`else
  localparam int MUL_LAT = 1;
`endif

  alu_pipe_mc #(
    .WIDTH (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_dec    (op_dec),
    .A         (A),
    .B         (B),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ans_ex    (ans_ex),
    .ans_hi    (ans_hi),
    .flag_ex   (flag_ex),
    .err       (err),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Monitor: one transfer per negedge where valid and ready are both high
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.nm, ".ans"},   {16'h0, ans_ex},   {16'h0, e.ans});
          chk({e.nm, ".hi"},    {16'h0, ans_hi},   {16'h0, e.hi});
          chk({e.nm, ".flags"}, {28'h0, flag_ex},  {28'h0, e.fl});
          chk({e.nm, ".err"},   {31'h0, err},      {31'h0, e.er});
          chk({e.nm, ".dout"},  {16'h0, data_out}, {16'h0, e.dout});
        end
      end
    end
  end

  // Present one op, wait (bounded) for in_ready, push expectation, complete the accept edge
  task automatic send(input string nm, input logic [5:0] op, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] din, input logic [15:0] e_ans,
                      input logic [15:0] e_hi, input logic [3:0] e_fl, input logic e_err,
                      input bit push, output int waited);
    exp_t e;
    in_valid = 1'b1;
    op_dec   = op;
    A        = a;
    B        = b;
    data_in  = din;
    waited   = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 100) begin
        chk({nm, ".accept_timeout"}, 32'd1, 32'd0);
        in_valid = 1'b0;
        return;
      end
    end
    if (push) begin
      e = '{nm, e_ans, e_hi, e_fl, e_err, exp_dout};
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic op1(input string nm, input logic [5:0] op, input logic [15:0] a,
                     input logic [15:0] b, input logic [15:0] e_ans, input logic [3:0] e_fl);
    int w;
    send(nm, op, a, b, 16'h0, e_ans, 16'h0, e_fl, 1'b0, 1'b1, w);
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string nm);
    @(negedge clk);
    chk({nm, ".out_valid"}, {31'h0, out_valid}, 32'd0);
    chk({nm, ".in_ready"},  {31'h0, in_ready},  32'd1);
    chk({nm, ".ans_ex"},    {16'h0, ans_ex},    32'd0);
    chk({nm, ".ans_hi"},    {16'h0, ans_hi},    32'd0);
    chk({nm, ".flags"},     {28'h0, flag_ex},   32'd0);
    chk({nm, ".err"},       {31'h0, err},       32'd0);
    chk({nm, ".data_out"},  {16'h0, data_out},  32'd0);
  endtask

  initial begin
    int w;
    int lat;
    int rdy_seen;
    int v_seen;

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_idle("reset");
    @(posedge clk);
    #1;

    // Back-to-back directed vectors, flags are {V,N,Z,C}
    op1("add",   6'h00, 16'h4000, 16'hC000, 16'h0000, 4'b0011);
    op1("adc",   6'h01, 16'h0001, 16'h0001, 16'h0003, 4'b0000);
    op1("sub",   6'h02, 16'h4000, 16'hC000, 16'h8000, 4'b1101);
    op1("cmp",   6'h0F, 16'h4000, 16'hC000, 16'h4000, 4'b1101);
    op1("sbb",   6'h03, 16'h0005, 16'h0003, 16'h0001, 4'b0000);
    op1("and",   6'h04, 16'hF0F0, 16'hFF00, 16'hF000, 4'b0100);
    op1("or",    6'h05, 16'h00F0, 16'h0F00, 16'h0FF0, 4'b0000);
    op1("xor",   6'h06, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b0010);
    op1("not",   6'h07, 16'h0000, 16'h0000, 16'hFFFF, 4'b0100);
    op1("shl",   6'h08, 16'h8001, 16'h0001, 16'h0002, 4'b0001);
    op1("shr",   6'h09, 16'h0003, 16'h0001, 16'h0001, 4'b0001);
    op1("sra",   6'h0A, 16'h8000, 16'h0004, 16'hF800, 4'b0100);
    op1("rol",   6'h0B, 16'h8001, 16'h0001, 16'h0003, 4'b0001);
    op1("ror",   6'h0C, 16'h0001, 16'h0001, 16'h8000, 4'b0101);
    send("illegal", 6'h3F, 16'h1111, 16'h2222, 16'h0, 16'h0000, 16'h0, 4'b0000, 1'b1, 1'b1, w);
    // Carry left at 1 by ROR must survive the illegal op
    op1("adc_keep", 6'h01, 16'h0000, 16'h0000, 16'h0001, 4'b0000);
    op1("inc_wrap", 6'h0D, 16'hFFFF, 16'h0000, 16'h0000, 4'b0011);
    op1("inc_ovf",  6'h0D, 16'h7FFF, 16'h0000, 16'h8000, 4'b1100);
    op1("dec_wrap", 6'h0E, 16'h0000, 16'h0000, 16'hFFFF, 4'b0101);
    op1("dec_ovf",  6'h0E, 16'h8000, 16'h0000, 16'h7FFF, 4'b1000);
    op1("shl_zero", 6'h08, 16'h8000, 16'h0010, 16'h8000, 4'b0100);
    op1("movb",     6'h10, 16'h0000, 16'h1234, 16'h1234, 4'b0000);
    send("in", 6'h11, 16'h0000, 16'h0000, 16'h0008, 16'h0008, 16'h0, 4'b0000, 1'b0, 1'b1, w);
    exp_dout = 16'h1234;
    op1("out",      6'h12, 16'h1234, 16'h0000, 16'h1234, 4'b0000);
    drain();

    // Stall: result must hold while out_ready is low, then next op accepted immediately
    out_ready = 1'b0;
    op1("and_stall", 6'h04, 16'h0F0F, 16'h00FF, 16'h000F, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall.out_valid", {31'h0, out_valid}, 32'd1);
      chk("stall.ans_ex",    {16'h0, ans_ex},    32'h000F);
      chk("stall.flags",     {28'h0, flag_ex},   32'd0);
      chk("stall.in_ready",  {31'h0, in_ready},  32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send("or_after", 6'h05, 16'h00F0, 16'h0F00, 16'h0, 16'h0FF0, 16'h0, 4'b0000, 1'b0, 1'b1, w);
    chk("release.same_cycle_accept", w, 32'd0);
    drain();

    // MUL latency and in_ready while busy
`ifdef ALU_MUL_EN
    send("mul", 6'h18, 16'hC000, 16'h0001, 16'h0, 16'hC000, 16'h0000, 4'b0100, 1'b0, 1'b1, w);
`else
    send("mul", 6'h18, 16'hC000, 16'h0001, 16'h0, 16'h0000, 16'h0000, 4'b0000, 1'b1, 1'b1, w);
`endif
    lat = 0;
    rdy_seen = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
      if (in_ready) rdy_seen++;
    end
    chk("mul.latency", lat, MUL_LAT);
    chk("mul.in_ready_busy", rdy_seen, 32'd0);
    drain();
`ifdef ALU_MUL_EN
    send("mul_max", 6'h18, 16'hFFFF, 16'hFFFF, 16'h0, 16'h0001, 16'hFFFE, 4'b0000, 1'b0, 1'b1, w);
`else
    send("mul_max", 6'h18, 16'hFFFF, 16'hFFFF, 16'h0, 16'h0000, 16'h0000, 4'b0000, 1'b1, 1'b1, w);
`endif
    drain();

    // Reset 5 cycles into a MUL: nothing may emerge afterwards
    out_ready = 1'b0;
    send("mul_abort", 6'h18, 16'h0003, 16'h0005, 16'h0, 16'h0, 16'h0, 4'b0, 1'b0, 1'b0, w);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    exp_dout = 16'h0000;
    check_idle("abort");
    v_seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (out_valid) v_seen++;
    end
    chk("abort.no_out_valid", v_seen, 32'd0);
    @(posedge clk);
    #1;
    // Carry was cleared by reset, so ADC behaves as ADD
    op1("adc_post_reset", 6'h01, 16'h0001, 16'h0002, 16'h0003, 4'b0000);
    op1("add_post_reset", 6'h00, 16'h0010, 16'h0020, 16'h0030, 4'b0000);
    drain();

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
